// File: rtl/spu_pkg.sv
// Shared definitions for the SPU packed pin interface: opcodes, field widths,
// bit positions on ui_in/uio_in and the command initiator's state encoding.
package spu_pkg;

    // Opcodes carried in uio_in[7:6]
    localparam logic [1:0] OP_FOCAL_MEAN = 2'b00;
    localparam logic [1:0] OP_MANHATTAN  = 2'b01;
    localparam logic [1:0] OP_BOX_AREA   = 2'b10;
    localparam logic [1:0] OP_TENSOR_MUL = 2'b11;

    // Field widths
    localparam int unsigned A_W      = 4;
    localparam int unsigned B_W      = 4;
    localparam int unsigned C_W      = 3;
    localparam int unsigned D_W      = 3;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned RESULT_W = 8;
    localparam int unsigned BUS_W    = 8;

    // Field LSB positions; A/B live on ui_in, C/D/OP on uio_in
    localparam int unsigned A_LSB  = 0;
    localparam int unsigned B_LSB  = 4;
    localparam int unsigned C_LSB  = 0;
    localparam int unsigned D_LSB  = 3;
    localparam int unsigned OP_LSB = 6;

    // Initiator FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } spu_state_e;

    // Build the ui_in byte from operands A and B: {B, A}
    function automatic logic [BUS_W-1:0] pack_ui(input logic [A_W-1:0] a,
                                                 input logic [B_W-1:0] b);
        logic [BUS_W-1:0] v;
        v = '0;
        v[A_LSB +: A_W] = a;
        v[B_LSB +: B_W] = b;
        return v;
    endfunction

    // Build the uio_in byte from opcode and operands C and D: {OP, D, C}
    function automatic logic [BUS_W-1:0] pack_uio(input logic [OP_W-1:0] op,
                                                  input logic [C_W-1:0]  c,
                                                  input logic [D_W-1:0]  d);
        logic [BUS_W-1:0] v;
        v = '0;
        v[C_LSB  +: C_W]  = c;
        v[D_LSB  +: D_W]  = d;
        v[OP_LSB +: OP_W] = op;
        return v;
    endfunction

endpackage

// File: rtl/spu_cmd_initiator.sv
// Command initiator for the SPU pin interface. Accepts one command, drives it
// onto ui_in/uio_in, waits SETTLE_CYCLES edges for the combinational SPU to
// settle, captures uo_out and hands it back over a valid/ready response port.
module spu_cmd_initiator
    import spu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,   // legal 1..15
    parameter int unsigned CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [A_W-1:0]      cmd_a,
    input  logic [B_W-1:0]      cmd_b,
    input  logic [C_W-1:0]      cmd_c,
    input  logic [D_W-1:0]      cmd_d,

    output logic [BUS_W-1:0]    spu_ui,
    output logic [BUS_W-1:0]    spu_uio,
    input  logic [RESULT_W-1:0] spu_uo,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_data,
    output logic [OP_W-1:0]     rsp_op,

    output logic                busy,
    output logic [CNT_W-1:0]    txn_count
);

    localparam int unsigned SETTLE_W = 4;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    spu_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [BUS_W-1:0]    spu_ui_q, spu_ui_d;
    logic [BUS_W-1:0]    spu_uio_q, spu_uio_d;
    logic [RESULT_W-1:0] rsp_data_q, rsp_data_d;
    logic [OP_W-1:0]     rsp_op_q, rsp_op_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]    txn_count_q, txn_count_d;

    // Next-state logic: accept in IDLE, count down in WAIT, hand off in RESP
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        op_d         = op_q;
        spu_ui_d     = spu_ui_q;
        spu_uio_d    = spu_uio_q;
        rsp_data_d   = rsp_data_q;
        rsp_op_d     = rsp_op_q;
        rsp_valid_d  = rsp_valid_q;
        txn_count_d  = txn_count_q;

        unique case (state_q)
            StIdle: begin
                // cmd_ready is high throughout IDLE, so valid alone completes the handshake
                if (cmd_valid) begin
                    spu_ui_d     = pack_ui(cmd_a, cmd_b);
                    spu_uio_d    = pack_uio(cmd_op, cmd_c, cmd_d);
                    op_d         = cmd_op;
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end else begin
                    rsp_data_d  = spu_uo;
                    rsp_op_d    = op_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                // Returning to IDLE here keeps the handshake edge free of a new accept
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; the SPU bus only clears on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            op_q         <= '0;
            spu_ui_q     <= '0;
            spu_uio_q    <= '0;
            rsp_data_q   <= '0;
            rsp_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            txn_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            op_q         <= op_d;
            spu_ui_q     <= spu_ui_d;
            spu_uio_q    <= spu_uio_d;
            rsp_data_q   <= rsp_data_d;
            rsp_op_q     <= rsp_op_d;
            rsp_valid_q  <= rsp_valid_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign spu_ui    = spu_ui_q;
    assign spu_uio   = spu_uio_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_spu_cmd_initiator.sv
// Bench for spu_cmd_initiator: a behavioural SPU stub answers on uo_out, and
// each transaction is checked against expectations computed from the command.
module tb_spu_cmd_initiator;
    import spu_pkg::*;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [3:0]       cmd_a = '0;
    logic [3:0]       cmd_b = '0;
    logic [2:0]       cmd_c = '0;
    logic [2:0]       cmd_d = '0;
    logic [7:0]       spu_ui;
    logic [7:0]       spu_uio;
    logic [7:0]       spu_uo;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [7:0]       rsp_data;
    logic [1:0]       rsp_op;
    logic             busy;
    logic [CNT_W-1:0] txn_count;

    int n_asserts = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_txn = 0;
    int last_accept = -100;

    spu_cmd_initiator #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_c     (cmd_c),
        .cmd_d     (cmd_d),
        .spu_ui    (spu_ui),
        .spu_uio   (spu_uio),
        .spu_uo    (spu_uo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Behavioural SPU result for one command
    function automatic logic [7:0] spu_ref(input logic [1:0] op, input int a, input int b,
                                           input int c, input int d);
        int r;
        case (op)
            2'b00:   r = (a + b + c + d) / 4;
            2'b01:   r = iabs(a - c) + iabs(b - d);
            2'b10:   r = iabs(c - a) * iabs(b - d);
            default: r = a * b;
        endcase
        return 8'(r);
    endfunction

    // SPU stub: decodes the pin buses back into fields
    always_comb begin
        spu_uo = spu_ref(spu_uio[7:6], int'(spu_ui[3:0]), int'(spu_ui[7:4]),
                         int'(spu_uio[2:0]), int'(spu_uio[5:3]));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold keeps cmd_valid/rsp_ready asserted across calls
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [2:0] c, input logic [2:0] d,
                           input int stall, input bit hold, input bit chk_period);
        logic [7:0] exp_ui;
        logic [7:0] exp_uio;
        logic [7:0] exp_res;
        int n;
        exp_ui  = {b, a};
        exp_uio = {op, d, c};
        exp_res = spu_ref(op, a, b, c, d);
        rsp_ready = hold && (stall == 0);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " accept_timeout"}, 32'(n < 50), 1);
        @(posedge clk); #1;
        if (chk_period) check({tag, " period"}, cyc - last_accept, SETTLE + 2);
        last_accept = cyc;
        if (!hold) cmd_valid = 1'b0;
        // Junk on the command inputs must not reach the bus
        cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        cmd_c = 3'($urandom); cmd_d = 3'($urandom);
        check({tag, " spu_ui"}, spu_ui, exp_ui);
        check({tag, " spu_uio"}, spu_uio, exp_uio);
        check({tag, " busy_wait"}, busy, 1);
        check({tag, " cmd_ready_wait"}, cmd_ready, 0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " settle_edges"}, n, SETTLE);
        check({tag, " rsp_data"}, rsp_data, exp_res);
        check({tag, " rsp_op"}, rsp_op, op);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, " stall_valid"}, rsp_valid, 1);
            check({tag, " stall_data"}, rsp_data, exp_res);
            check({tag, " stall_cmd_ready"}, cmd_ready, 0);
            check({tag, " stall_count"}, txn_count, 32'(exp_txn % 16));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_txn++;
        check({tag, " rsp_valid_drop"}, rsp_valid, 0);
        check({tag, " txn_count"}, txn_count, 32'(exp_txn % 16));
        check({tag, " cmd_ready_idle"}, cmd_ready, 1);
        check({tag, " busy_idle"}, busy, 0);
        check({tag, " ui_held"}, spu_ui, exp_ui);
        check({tag, " uio_held"}, spu_uio, exp_uio);
        if (!hold) rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst spu_ui", spu_ui, 0);
        check("rst spu_uio", spu_uio, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_op", rsp_op, 0);
        check("rst txn_count", txn_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);

        // Focal mean
        run_txn("focal", OP_FOCAL_MEAN, 4'd4, 4'd8, 3'd6, 3'd2, 0, 1'b0, 1'b0);
        // Manhattan back-to-back, cmd_valid and rsp_ready held high
        run_txn("manh0", OP_MANHATTAN, 4'd5, 4'd3, 3'd1, 3'd7, 0, 1'b1, 1'b0);
        run_txn("manh1", OP_MANHATTAN, 4'd5, 4'd3, 3'd1, 3'd7, 0, 1'b1, 1'b1);
        run_txn("b2b", 2'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
                3'($urandom), 0, 1'b1, 1'b1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        // Box area with long backpressure
        run_txn("box", OP_BOX_AREA, 4'd2, 4'd3, 3'd5, 3'd1, 10, 1'b0, 1'b0);
        // Tensor multiply
        run_txn("tensor", OP_TENSOR_MUL, 4'd2, 4'd3, 3'd4, 3'd5, 1, 1'b0, 1'b0);

        // Reset one cycle after accept
        cmd_op = OP_MANHATTAN; cmd_a = 4'd9; cmd_b = 4'd1; cmd_c = 3'd3; cmd_d = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("midrst busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst spu_ui", spu_ui, 0);
        check("midrst spu_uio", spu_uio, 0);
        check("midrst txn_count", txn_count, 0);
        check("midrst rsp_valid", rsp_valid, 0);
        exp_txn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst no_rsp", rsp_valid, 0);
        end
        run_txn("post_rst", OP_TENSOR_MUL, 4'd7, 4'd6, 3'd2, 3'd3, 0, 1'b0, 1'b0);

        // Random traffic up to 17 transactions since reset to exercise the wrap
        for (int k = 2; k <= 17; k++) begin
            run_txn("rand", 2'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
                    3'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
            if (k == 15) check("wrap15", txn_count, 32'hF);
            if (k == 16) check("wrap16", txn_count, 32'h0);
            if (k == 17) check("wrap17", txn_count, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
